// File: rtl/pipeline_skid_register.sv
// -----------------------------------------------------------------------------
// pipeline_skid_register
//
// Pipeline register between the execute and memory stages of a CPU. It carries
// the packed M+WB control field plus the ALU result, zero flag, store data,
// func3 and destination register. The handshake is valid/ready on both sides.
//
// With skid_enable=1 the block is a two-entry skid buffer. in_ready is a pure
// flop output, so there is no combinational path from out_ready back
// upstream. The second (skid) entry absorbs the one beat that can arrive while
// the downstream stall is still propagating.
//
// With skid_enable=0 the block is a single-entry register. Its in_ready
// follows out_ready combinationally, and no skid storage is built.
//
// Ports
//   clk             : single clock, every flop updates on the rising edge
//   n_reset         : asynchronous active-low reset
//   clear_pipeline  : synchronous flush of all held entries (valid bits only)
//   in_valid        : upstream offers a beat
//   in_ready        : this stage accepts a beat on the next edge
//   in_ctrl         : packed M+WB control field           [ctrl_bits]
//   in_alu_result   : ALU result                          [data_bits]
//   in_alu_zero     : ALU zero flag
//   in_store_data   : store data                          [data_bits]
//   in_func3        : instruction func3                   [3]
//   in_rd           : destination register index          [5]
//   out_valid       : a beat is presented downstream
//   out_ready       : downstream takes the beat on the next edge
//   out_*           : the oldest held beat; out_ctrl reads zero on a bubble
//   occupancy       : number of held entries, 0..2 (registered)
// -----------------------------------------------------------------------------
module pipeline_skid_register #(
    parameter int data_bits   = 32,
    parameter int ctrl_bits   = 8,
    parameter bit skid_enable = 1'b1
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 clear_pipeline,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ctrl_bits-1:0] in_ctrl,
    input  logic [data_bits-1:0] in_alu_result,
    input  logic                 in_alu_zero,
    input  logic [data_bits-1:0] in_store_data,
    input  logic [2:0]           in_func3,
    input  logic [4:0]           in_rd,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ctrl_bits-1:0] out_ctrl,
    output logic [data_bits-1:0] out_alu_result,
    output logic                 out_alu_zero,
    output logic [data_bits-1:0] out_store_data,
    output logic [2:0]           out_func3,
    output logic [4:0]           out_rd,

    output logic [1:0]           occupancy
);

    localparam int PAY_W = ctrl_bits + data_bits + 1 + data_bits + 3 + 5;

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [PAY_W-1:0]   main_q, main_d;
    logic [PAY_W-1:0]   skid_q;
    logic [PAY_W-1:0]   in_payload;
    logic [ctrl_bits-1:0] main_ctrl;
    logic               skid_load;
    logic               in_fire;
    logic               out_fire;

    assign in_payload = {in_ctrl, in_alu_result, in_alu_zero,
                         in_store_data, in_func3, in_rd};

    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = 2'(state_q);

    // in_ready_q is low through reset and for the first edge after it. In
    // skid mode it is the whole ready. In single-entry mode it only gates
    // the combinational pass-through.
    generate
        if (skid_enable) begin : g_ready_reg
            assign in_ready = in_ready_q;
        end else begin : g_ready_comb
            assign in_ready = in_ready_q && (!out_valid || out_ready);
        end
    endgenerate

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_load  = 1'b0;
        in_ready_d = 1'b1;

        if (clear_pipeline) begin
            // The flush drops valid bits only. Payload flops keep their old
            // contents, and the incoming beat is discarded.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_payload;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_payload;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat behind main.
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        if (skid_enable) begin
            in_ready_d = (state_d != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
        end
    end

    generate
        if (skid_enable) begin : g_skid
            logic [PAY_W-1:0] skid_d;

            always_comb begin
                skid_d = skid_q;
                if (skid_load) begin
                    skid_d = in_payload;
                end
            end

            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    skid_q <= '0;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    assign {main_ctrl, out_alu_result, out_alu_zero,
            out_store_data, out_func3, out_rd} = main_q;

    // A bubble must never carry mem_write/reg_write into the next stage.
    assign out_ctrl = out_valid ? main_ctrl : '0;

`ifndef SYNTHESIS
    a_full_not_ready: assert property (@(posedge clk) disable iff (!n_reset)
        (state_q == ST_FULL) |-> !in_ready);

    a_bubble_ctrl: assert property (@(posedge clk) disable iff (!n_reset)
        !out_valid |-> (out_ctrl == '0));

    a_hold_stalled: assert property (@(posedge clk) disable iff (!n_reset)
        (out_valid && !out_ready && !clear_pipeline) |=> $stable(main_q));
`endif

endmodule
